// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Quotient goes to LO, remainder to HI. div_ready tells the hazard unit
// when the E stage may advance. Fixed latency of WIDTH+1 cycles from start.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             div_ack,
    input  logic             div_cancel,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_start;
    logic             w_last;
    logic             w_finish;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Operand magnitudes; signs only count for DIV.
    assign w_a_neg = div_signed & opa[WIDTH-1];
    assign w_b_neg = div_signed & opb[WIDTH-1];
    assign w_a_mag = w_a_neg ? -opa : opa;
    assign w_b_mag = w_b_neg ? -opb : opb;

    assign w_start  = (r_state == IDLE) & div_en & ~div_cancel;
    assign w_last   = (r_state == BUSY) & (r_cnt == CW'(1));
    assign w_finish = w_last & ~div_cancel;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the trial difference when it did not borrow.
    assign w_sh      = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_sh - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    // Quotient negated when signs differ, remainder follows the dividend.
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) unnegated.
    assign w_q_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    assign div_ready = (r_state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state; cancel wins over ack and over a start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (div_en)  w_state_nxt = BUSY;
            BUSY:    if (w_last)  w_state_nxt = DONE;
            DONE:    if (div_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (div_cancel) w_state_nxt = IDLE;
    end

    // Datapath: latch operands at start, iterate in BUSY, register results
    // only on the final step so they hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (w_start) begin
            r_cnt   <= CW'(WIDTH);
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (w_finish) begin
                quotient  <= w_q_fix;
                remainder <= w_r_fix;
            end
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: scoreboard bench. Stimulus pushes expected results and the
// cycle at which div_ready must first rise; a monitor pops on each rising
// div_ready and compares quotient, remainder and arrival cycle.
module tb_mdu_divider;

    logic        clk        = 1'b0;
    logic        resetn     = 1'b0;
    logic        div_en     = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] opa        = '0;
    logic [31:0] opb        = '0;
    logic        div_ack    = 1'b0;
    logic        div_cancel = 1'b0;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    mdu_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_en     (div_en),
        .div_signed (div_signed),
        .opa        (opa),
        .opb        (opb),
        .div_ack    (div_ack),
        .div_cancel (div_cancel),
        .div_ready  (div_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          at;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge of div_ready.
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (div_ready && !prev_rdy) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: ready rose at cycle %0d with nothing pending", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("ready_cycle", cyc, e.at);
            end
        end
        prev_rdy <= div_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!div_ready && n < 60) begin
            step();
            n++;
        end
        if (!div_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: ready still %b after %0d cycles, want 1", nm, div_ready, n);
        end
    endtask

    // Start a divide; operands are scrambled after the start edge since the
    // divider must only sample them once.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r);
        div_en     = 1'b1;
        div_signed = s;
        opa        = a;
        opb        = b;
        sb.push_back('{q, r, cyc + 33});
        step();
        opa = 32'hDEADBEEF;
        opb = 32'h0BADF00D;
    endtask

    task automatic finish_ack();
        div_ack = 1'b1;
        step();
        div_ack = 1'b0;
        div_en  = 1'b0;
        chk("ready_drop", {31'b0, div_ready}, 32'd0);
    endtask

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r);
        issue(s, a, b, q, r);
        wait_ready("div");
        finish_ack();
    endtask

    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = (s && a[31]) ? 32'h1 : 32'hFFFFFFFF;
            r = a;
        end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'h0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        int          hi;

        // Reset state.
        step();
        step();
        chk("rst_ready", {31'b0, div_ready}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        resetn = 1'b1;
        step();

        // Directed divides.
        do_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1);
        do_div(1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        do_div(1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        do_div(1'b0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234);
        do_div(1'b1, 32'hFFFFFFFB, 32'h0, 32'h1, 32'hFFFFFFFB);
        do_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
        do_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hE, 32'hFFFFFFFE);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // Cancel on cycle 10 of a divide: no result may appear.
        div_en     = 1'b1;
        div_signed = 1'b0;
        opa        = 32'd50;
        opb        = 32'd3;
        step();
        repeat (9) step();
        div_cancel = 1'b1;
        step();
        div_cancel = 1'b0;
        div_en     = 1'b0;
        hi = 0;
        repeat (40) begin
            step();
            if (div_ready) hi++;
        end
        chk("cancel_ready_cycles", hi, 32'd0);
        do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        // DONE held without ack, then back-to-back start with div_en held.
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
        wait_ready("hold");
        repeat (3) begin
            step();
            chk("hold_ready", {31'b0, div_ready}, 32'd1);
            chk("hold_quotient", quotient, 32'd100);
            chk("hold_remainder", remainder, 32'd0);
        end
        div_ack = 1'b1;
        opa     = 32'd9;
        opb     = 32'd4;
        sb.push_back('{32'd2, 32'd1, cyc + 34});
        step();
        div_ack = 1'b0;
        chk("b2b_drop", {31'b0, div_ready}, 32'd0);
        step();
        opa = 32'hDEADBEEF;
        opb = 32'h0BADF00D;
        wait_ready("b2b");
        finish_ack();

        // Reset asserted on cycle 15 of a divide.
        div_en     = 1'b1;
        div_signed = 1'b0;
        opa        = 32'h12345678;
        opb        = 32'd3;
        step();
        repeat (14) step();
        resetn = 1'b0;
        step();
        chk("midrst_ready", {31'b0, div_ready}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        resetn = 1'b1;
        div_en = 1'b0;
        step();

        // Random pairs against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 3 == 1) rb = ~rb + 32'd1 & 32'h8000000F | 32'hFFFFFFF0;
            rs = i[0];
            model(rs, ra, rb, rq, rr);
            do_div(rs, ra, rb, rq, rr);
        end

        step();
        step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
